// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and geometry for the cache-line to burst-memory adaptor.
package cacheline_adaptor_pkg;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 5;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
  typedef logic [1:0] beat_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction
endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line request into a 4-beat 64-bit burst and answers with a one-cycle pmem_resp.
// CACHELINE_ADAPTOR_WATCHDOG_EN adds a stall watchdog with a sticky err_o.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  #(parameter int TIMEOUT_CYCLES = 1024)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [ADDR_W-1:0] bmem_address,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  ,
  output logic              err_o
`endif
);

  state_t            state;
  beat_t             beat;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] line_next;
  logic              timeout;
  logic              last_beat;

  // Line with the incoming beat merged, so the final beat can go straight into pmem_rdata.
  always_comb begin
    line_next = line_buf;
    line_next[int'(beat)*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  assign bmem_wdata = line_buf[int'(beat)*BEAT_W +: BEAT_W];
  assign last_beat  = (beat == beat_t'(BEATS - 1));

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_burst;

  assign in_burst = (state == RD_BURST) || (state == WR_BURST);
  assign timeout  = in_burst && !bmem_resp && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_o  <= 1'b0;
    end else if (in_burst && !bmem_resp) begin
      wd_cnt <= timeout ? '0 : wd_cnt + 1'b1;
      if (timeout) err_o <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat         <= '0;
      line_buf     <= '0;
      pmem_rdata   <= '0;
      pmem_resp    <= 1'b0;
      bmem_read    <= 1'b0;
      bmem_write   <= 1'b0;
      bmem_address <= '0;
    end else begin
      pmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          beat <= '0;
          if (pmem_write) begin
            line_buf     <= pmem_wdata;
            bmem_address <= line_align(pmem_address);
            bmem_write   <= 1'b1;
            state        <= WR_BURST;
          end else if (pmem_read) begin
            bmem_address <= line_align(pmem_address);
            bmem_read    <= 1'b1;
            state        <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (bmem_resp) begin
            line_buf <= line_next;
            beat     <= beat + 1'b1;
            if (last_beat) begin
              pmem_rdata <= line_next;
              bmem_read  <= 1'b0;
              pmem_resp  <= 1'b1;
              state      <= DONE;
            end
          end else if (timeout) begin
            pmem_rdata <= line_buf;
            bmem_read  <= 1'b0;
            beat       <= '0;
            pmem_resp  <= 1'b1;
            state      <= DONE;
          end
        end
        WR_BURST: begin
          if (bmem_resp) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              bmem_write <= 1'b0;
              pmem_resp  <= 1'b1;
              state      <= DONE;
            end
          end else if (timeout) begin
            bmem_write <= 1'b0;
            beat       <= '0;
            pmem_resp  <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
